meter_sched: RTL and testbench
==============================

METER_SCHED -- requirements
Module: meter_sched

Interface
REQ-001 Parameter PERIOD_W, default 24, width of the sample-period register.
REQ-002 Parameter BUSY_TO, default 4, max cycles from meter_start to meter_busy high.
REQ-003 Parameter DONE_TO, default 65535, max cycles meter_busy stays high per conversion.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 enable  in  1  periodic sampling enable.
REQ-007 period  in  PERIOD_W  cycles between periodic requests; 0 disables periodic requests.
REQ-008 oneshot_req  in  1  host single-measurement request (level, held until ack).
REQ-009 oneshot_ack  out  1  one-cycle pulse; oneshot request accepted.
REQ-010 meter_start  out  1  one-cycle start pulse to the meter block.
REQ-011 meter_busy  in  1  meter busy flag.
REQ-012 meter_v, meter_i  in  22 each  meter averaged voltage / current results.
REQ-013 v_limit, i_limit  in  22 each  trip thresholds.
REQ-014 sample_v, sample_i  out  22 each  last captured results.
REQ-015 sample_valid  out  1  one-cycle pulse; sample_v/i updated.
REQ-016 trip  out  1  sticky over-limit flag.
REQ-017 timeout_err  out  1  sticky meter-timeout flag.
REQ-018 clr  in  1  clears trip and timeout_err.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE.
REQ-021 Period timer SHALL count while enable=1 and period!=0, set pend_per on reaching period-1, then restart from 0; enable=0 or period=0 holds timer at 0 and clears pend_per.
REQ-022 pend_per raised while not IDLE SHALL be held (not lost, not counted twice) until serviced.
REQ-023 IDLE with oneshot_req=1 or pend_per=1 SHALL go to ISSUE next cycle; oneshot_ack pulses in that transition cycle if oneshot_req=1.
REQ-024 oneshot and periodic pending together SHALL be served by one conversion, clearing both.
REQ-025 ISSUE SHALL assert meter_start for exactly one cycle, then go to WAIT_BUSY.
REQ-026 WAIT_BUSY SHALL go to WAIT_DONE on meter_busy=1; after BUSY_TO cycles without it, set timeout_err and return to IDLE.
REQ-027 WAIT_DONE SHALL go to CAPTURE on meter_busy=0; after DONE_TO cycles of busy, set timeout_err and return to IDLE.
REQ-028 CAPTURE SHALL load sample_v/i from meter_v/i, then return to IDLE; sample_valid and new sample values appear the cycle after CAPTURE.
REQ-029 trip SHALL set in that same cycle if meter_v > v_limit or meter_i > i_limit (strict, unsigned 22-bit compare); equality does not trip.
REQ-030 Timed-out conversions SHALL NOT pulse sample_valid nor change sample_v/i/trip.
REQ-031 clr SHALL clear flags next cycle; clr coincident with a set event SHALL leave the flag set.
REQ-032 Latency oneshot_req (IDLE) to meter_start SHALL be 2 cycles.

Reset
REQ-033 rst SHALL force IDLE, timer 0, pend_per 0, all outputs 0 (sample_v/i 0, flags 0, pulses 0).
REQ-034 rst mid-conversion SHALL abandon it with no sample_valid; meter block is reset by the same rst.

Structure
REQ-035 meter_pkg SHALL hold state encoding, data width 22, BUSY_TO/DONE_TO defaults.
REQ-036 Period timer SHALL be sub-module period_timer (enable, period, tick out).

Verification
REQ-037 oneshot_req=1, meter model busy 10 cycles, meter_v=805 -> ack, meter_start at +2, sample_valid once, sample_v=805, trip=0.
REQ-038 enable=1, period=100, 3 conversions of 20 cycles -> meter_start every 100 cycles, 3 sample_valid pulses.
REQ-039 v_limit=1000, meter_v=1000 then 1001 -> trip 0 after first, 1 after second; clr -> 0.
REQ-040 meter_busy never rises -> timeout_err=1 after BUSY_TO cycles, no sample_valid, busy=0.
REQ-041 oneshot_req and period tick same cycle -> exactly one meter_start, both cleared.
REQ-042 rst during WAIT_DONE -> all outputs 0 next cycle, no sample_valid.

Source files
------------

// File: rtl/meter_pkg.sv
// meter_pkg
// Shared definitions for the meter scheduler: result data width, default
// conversion watchdog limits, scheduler state encoding and the over-limit
// comparison used when a sample is captured.
package meter_pkg;

  localparam int DATA_W      = 22;
  localparam int BUSY_TO_DEF = 4;
  localparam int DONE_TO_DEF = 65535;

  typedef logic [DATA_W-1:0] data_t;

  // Scheduler states (plain constants to stay compatible with older tools)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;

  // Strict unsigned compare: a result equal to its limit does not trip.
  function automatic logic over_limit(input data_t v, input data_t i,
                                      input data_t v_lim, input data_t i_lim);
    return (v > v_lim) || (i > i_lim);
  endfunction

endpackage

// File: rtl/meter_sched_if.sv
// meter_sched_if
// Groups the host one-shot handshake, the meter block handshake/results and
// the captured-sample outputs of the meter scheduler.
//   slave  : scheduler side (drives ack, start, samples)
//   master : host + meter side (drives request, meter busy and results)
interface meter_sched_if;

  logic               oneshot_req;
  logic               oneshot_ack;
  logic               meter_start;
  logic               meter_busy;
  meter_pkg::data_t   meter_v;
  meter_pkg::data_t   meter_i;
  meter_pkg::data_t   sample_v;
  meter_pkg::data_t   sample_i;
  logic               sample_valid;

  modport slave (
    input  oneshot_req, meter_busy, meter_v, meter_i,
    output oneshot_ack, meter_start, sample_v, sample_i, sample_valid
  );

  modport master (
    output oneshot_req, meter_busy, meter_v, meter_i,
    input  oneshot_ack, meter_start, sample_v, sample_i, sample_valid
  );

endinterface

// File: rtl/period_timer.sv
// period_timer
// Free-running sample-period counter.
//   clk, rst : clock, synchronous active-high reset
//   enable   : counting enable
//   period   : cycles between ticks; 0 stops the timer
//   tick     : high in the cycle the count reaches period-1
module period_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_reg;
  logic                run;

  assign run  = enable && (period != '0);
  // >= keeps the timer from running away if period shrinks below the count
  assign tick = run && (cnt_reg >= (period - PERIOD_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || !run || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/meter_sched.sv
// meter_sched
// Schedules meter conversions from a periodic timer and host one-shot
// requests, supervises the meter busy handshake with watchdogs, captures the
// results and raises a sticky trip flag on over-limit samples.
//   clk, rst          : clock, synchronous active-high reset
//   enable, period    : periodic sampling control (period 0 = off)
//   mif               : one-shot handshake, meter handshake/results, samples
//   v_limit, i_limit  : trip thresholds
//   clr               : clears trip and timeout_err
//   trip, timeout_err : sticky flags
//   busy              : scheduler is not idle
module meter_sched
  import meter_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int BUSY_TO  = BUSY_TO_DEF,
  parameter int DONE_TO  = DONE_TO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  meter_sched_if.slave        mif,
  input  data_t               v_limit,
  input  data_t               i_limit,
  input  logic                clr,
  output logic                trip,
  output logic                timeout_err,
  output logic                busy
);

  localparam int TO_MAX = (BUSY_TO > DONE_TO) ? BUSY_TO : DONE_TO;
  localparam int WD_W   = $clog2(TO_MAX + 1);

  logic [2:0]      state_reg, state_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            pend_per_reg, pend_per_next;
  logic            ack_reg, ack_next;
  logic            start_reg, start_next;
  logic            valid_reg;
  data_t           sample_v_reg, sample_i_reg;
  logic            trip_reg, tout_reg;
  logic            capture, tout_set, tick, per_run;

  period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  assign per_run = enable && (period != '0);

  always_comb begin
    state_next    = state_reg;
    wd_next       = wd_reg;
    // A tick arriving mid-conversion is remembered once until serviced
    pend_per_next = per_run ? (pend_per_reg | tick) : 1'b0;
    ack_next      = 1'b0;
    start_next    = 1'b0;
    capture       = 1'b0;
    tout_set      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A live tick is treated as pending so a coincident one-shot and
        // tick collapse into a single conversion.
        if (mif.oneshot_req || pend_per_reg || tick) begin
          state_next    = ST_ISSUE;
          pend_per_next = 1'b0;
          ack_next      = mif.oneshot_req;
        end
      end
      ST_ISSUE: begin
        start_next = 1'b1;
        wd_next    = '0;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (mif.meter_busy) begin
          wd_next    = '0;
          state_next = ST_WAIT_DONE;
        end else if (wd_reg == WD_W'(BUSY_TO - 1)) begin
          tout_set   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!mif.meter_busy) begin
          state_next = ST_CAPTURE;
        end else if (wd_reg == WD_W'(DONE_TO - 1)) begin
          tout_set   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wd_reg       <= '0;
      pend_per_reg <= 1'b0;
      ack_reg      <= 1'b0;
      start_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      sample_v_reg <= '0;
      sample_i_reg <= '0;
      trip_reg     <= 1'b0;
      tout_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wd_reg       <= wd_next;
      pend_per_reg <= pend_per_next;
      ack_reg      <= ack_next;
      start_reg    <= start_next;
      valid_reg    <= capture;
      if (capture) begin
        sample_v_reg <= mif.meter_v;
        sample_i_reg <= mif.meter_i;
      end
      // Set has priority over a coincident clear
      trip_reg <= (capture && over_limit(mif.meter_v, mif.meter_i, v_limit, i_limit))
                  || (trip_reg && !clr);
      tout_reg <= tout_set || (tout_reg && !clr);
    end
  end

  assign mif.oneshot_ack  = ack_reg;
  assign mif.meter_start  = start_reg;
  assign mif.sample_valid = valid_reg;
  assign mif.sample_v     = sample_v_reg;
  assign mif.sample_i     = sample_i_reg;
  assign trip             = trip_reg;
  assign timeout_err      = tout_reg;
  assign busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_meter_sched.sv
// tb_meter_sched
// Self-checking bench for meter_sched: table of one-shot conversions with
// limit checks, plus hand-written sequences for watchdogs, periodic
// scheduling, coincident requests and reset mid-conversion.
module tb_meter_sched;
  import meter_pkg::*;

  localparam int PW  = 24;
  localparam int BTO = 4;
  localparam int DTO = 40;

  logic          clk = 1'b0;
  logic          rst, enable, clr;
  logic [PW-1:0] period;
  data_t         v_limit, i_limit;
  logic          trip, timeout_err, busy;

  meter_sched_if mif();

  meter_sched #(.PERIOD_W(PW), .BUSY_TO(BTO), .DONE_TO(DTO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
    .mif         (mif.slave),
    .v_limit     (v_limit),
    .i_limit     (i_limit),
    .clr         (clr),
    .trip        (trip),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Meter model: busy rises the cycle after meter_start, stays high model_len cycles
  int   model_len = 10;
  bit   model_never = 1'b0;
  int   rem = 0;
  logic mb = 1'b0;
  assign mif.meter_busy = mb;

  always @(posedge clk) begin
    if (rst) begin
      mb  <= 1'b0;
      rem <= 0;
    end else if (mif.meter_start && !model_never) begin
      mb  <= 1'b1;
      rem <= model_len;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else if (rem == 1) begin
      rem <= 0;
      mb  <= 1'b0;
    end
  end

  // Cycle counter and event monitors
  int cyc = 0;
  int start_cnt = 0, valid_cnt = 0, ack_cnt = 0, last_start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mif.meter_start === 1'b1) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
    end
    if (mif.sample_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (mif.oneshot_ack === 1'b1)  ack_cnt   <= ack_cnt + 1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_v"},     32'(mif.sample_v), 0);
    chk({tag, "_sample_i"},     32'(mif.sample_i), 0);
    chk({tag, "_sample_valid"}, 32'(mif.sample_valid), 0);
    chk({tag, "_ack"},          32'(mif.oneshot_ack), 0);
    chk({tag, "_start"},        32'(mif.meter_start), 0);
    chk({tag, "_trip"},         32'(trip), 0);
    chk({tag, "_timeout"},      32'(timeout_err), 0);
    chk({tag, "_busy"},         32'(busy), 0);
  endtask

  // Raise oneshot_req, hold until ack, drop it; c0 = cycle the request was raised
  task automatic req_oneshot(output int c0);
    bit acked = 1'b0;
    mif.oneshot_req = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mif.oneshot_ack === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    mif.oneshot_req = 1'b0;
    chk("oneshot_ack", 32'(acked), 1);
  endtask

  task automatic wait_valid(input int v0, input int budget);
    int k = 0;
    while (valid_cnt == v0 && k < budget) begin
      step();
      k++;
    end
    chk("sample_valid_seen", 32'(valid_cnt != v0), 1);
  endtask

  task automatic wait_timeout(input int budget);
    int k = 0;
    while (timeout_err !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("timeout_err_set", 32'(timeout_err), 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  typedef struct {
    data_t mv, mi, vl, il;
    bit    do_clr;
    bit    exp_trip;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, s0, a0, n, d;
    int st[3];

    vecs[0] = '{22'd805,     22'd10,   22'd1000,    22'd1000,    1'b0, 1'b0};
    vecs[1] = '{22'd1000,    22'd0,    22'd1000,    22'd1000,    1'b0, 1'b0};
    vecs[2] = '{22'd1001,    22'd0,    22'd1000,    22'd1000,    1'b0, 1'b1};
    vecs[3] = '{22'd500,     22'd500,  22'd1000,    22'd1000,    1'b0, 1'b1};
    vecs[4] = '{22'd500,     22'd500,  22'd1000,    22'd1000,    1'b1, 1'b0};
    vecs[5] = '{22'd0,       22'd2000, 22'd1000,    22'd2000,    1'b0, 1'b0};
    vecs[6] = '{22'd0,       22'd2001, 22'd1000,    22'd2000,    1'b0, 1'b1};
    vecs[7] = '{22'h3FFFFF,  22'd0,    22'h3FFFFF,  22'd0,       1'b1, 1'b0};
    vecs[8] = '{22'h3FFFFF,  22'd0,    22'h3FFFFE,  22'h3FFFFF,  1'b1, 1'b1};

    rst = 1'b1; enable = 1'b0; clr = 1'b0; period = '0;
    v_limit = '0; i_limit = '0;
    mif.oneshot_req = 1'b0; mif.meter_v = '0; mif.meter_i = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Table-driven one-shot conversions
    for (int n_i = 0; n_i < 9; n_i++) begin
      mif.meter_v = vecs[n_i].mv;
      mif.meter_i = vecs[n_i].mi;
      v_limit     = vecs[n_i].vl;
      i_limit     = vecs[n_i].il;
      if (vecs[n_i].do_clr) begin
        pulse_clr();
        chk("clr_trip", 32'(trip), 0);
      end
      model_len = 10;
      v0 = valid_cnt;
      req_oneshot(c0);
      wait_valid(v0, 200);
      repeat (3) step();
      chk("latency",      32'(last_start_cyc - c0), 2);
      chk("sample_v",     32'(mif.sample_v), 32'(vecs[n_i].mv));
      chk("sample_i",     32'(mif.sample_i), 32'(vecs[n_i].mi));
      chk("trip",         32'(trip), 32'(vecs[n_i].exp_trip));
      chk("valid_pulses", 32'(valid_cnt - v0), 1);
      chk("busy_idle",    32'(busy), 0);
      $display("vec %0d: v=%0d i=%0d vlim=%0d ilim=%0d -> sample_v=%0d trip=%0d",
               n_i, vecs[n_i].mv, vecs[n_i].mi, vecs[n_i].vl, vecs[n_i].il,
               mif.sample_v, trip);
    end

    // Meter never raises busy: watchdog after BUSY_TO cycles
    model_never = 1'b1;
    v0 = valid_cnt;
    mif.meter_v = 22'd7;
    req_oneshot(c0);
    wait_timeout(30);
    chk("busy_to_cycles",    32'(cyc - last_start_cyc), BTO);
    chk("busy_to_busy",      32'(busy), 0);
    chk("busy_to_no_valid",  32'(valid_cnt - v0), 0);
    chk("busy_to_sample_v",  32'(mif.sample_v), 32'(vecs[8].mv));
    pulse_clr();
    chk("clr_timeout", 32'(timeout_err), 0);
    $display("busy timeout: timeout_err set and cleared");

    // clr held during the set event: set wins, cleared the following cycle
    clr = 1'b1;
    req_oneshot(c0);
    wait_timeout(30);
    step();
    chk("clr_held_clears", 32'(timeout_err), 0);
    clr = 1'b0;
    model_never = 1'b0;
    $display("clr coincident with timeout set");

    // Meter stuck busy: watchdog in WAIT_DONE
    model_len = 100;
    v0 = valid_cnt;
    req_oneshot(c0);
    wait_timeout(80);
    d = cyc - last_start_cyc;
    chk("done_to_window",   32'(d >= DTO && d <= DTO + 3), 1);
    chk("done_to_busy",     32'(busy), 0);
    chk("done_to_no_valid", 32'(valid_cnt - v0), 0);
    chk("done_to_sample_v", 32'(mif.sample_v), 32'(vecs[8].mv));
    n = 0;
    while (mb === 1'b1 && n < 150) begin step(); n++; end
    chk("meter_model_idle", 32'(mb), 0);
    pulse_clr();
    $display("done timeout: after %0d cycles from start", d);

    // Periodic sampling every 100 cycles
    model_len = 20;
    s0 = start_cnt; v0 = valid_cnt; a0 = ack_cnt;
    enable = 1'b1; period = 24'd100;
    n = 0;
    for (int k = 0; k < 400 && n < 3; k++) begin
      step();
      if (start_cnt != s0 + n) begin
        st[n] = last_start_cyc;
        n++;
      end
    end
    enable = 1'b0;
    chk("periodic_starts", 32'(n), 3);
    chk("periodic_gap1",   32'(st[1] - st[0]), 100);
    chk("periodic_gap2",   32'(st[2] - st[1]), 100);
    repeat (40) step();
    chk("periodic_valids", 32'(valid_cnt - v0), 3);
    chk("periodic_no_ack", 32'(ack_cnt - a0), 0);
    $display("periodic: starts at %0d %0d %0d", st[0], st[1], st[2]);

    // Period 0 with enable, and enable 0 with a period: no conversions
    s0 = start_cnt;
    period = '0; enable = 1'b1;
    repeat (250) step();
    chk("period0_no_start", 32'(start_cnt - s0), 0);
    period = 24'd20; enable = 1'b0;
    repeat (100) step();
    chk("disabled_no_start", 32'(start_cnt - s0), 0);
    $display("period 0 / enable 0: no starts");

    // One-shot request coinciding with a timer tick: one conversion
    model_len = 10;
    period = 24'd50;
    s0 = start_cnt; a0 = ack_cnt;
    enable = 1'b1;
    repeat (49) step();
    mif.oneshot_req = 1'b1;
    step();
    chk("coinc_ack", 32'(mif.oneshot_ack), 1);
    mif.oneshot_req = 1'b0;
    repeat (45) step();
    chk("coinc_one_start", 32'(start_cnt - s0), 1);
    chk("coinc_one_ack",   32'(ack_cnt - a0), 1);
    repeat (10) step();
    chk("coinc_next_tick", 32'(start_cnt - s0), 2);
    enable = 1'b0;
    repeat (30) step();
    $display("coincident oneshot + tick: %0d starts in window", start_cnt - s0);

    // Reset in WAIT_DONE abandons the conversion
    model_len = 30;
    mif.meter_v = 22'd123;
    req_oneshot(c0);
    repeat (5) step();
    chk("rst_mid_busy_before", 32'(busy), 1);
    v0 = valid_cnt;
    rst = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    repeat (40) step();
    chk("rst_mid_no_valid", 32'(valid_cnt - v0), 0);
    chk("rst_mid_idle",     32'(busy), 0);
    $display("reset mid-conversion: outputs cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
